// File: rtl/note_keypad.sv
// 4x4 membrane keypad scanner: drives active-low columns, samples synchronized rows,
// debounces whole scans and publishes the accepted key code and its note frequency.
module note_keypad #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [11:0] freq,
    output logic [3:0]  key,
    output logic        key_down,
    output logic        note_on,
    output logic        new_note
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      c_q, c_d;
    logic [15:0]     scan_q, scan_d;
    logic [4:0]      prev_q, prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [11:0]     freq_q, freq_d;
    logic [3:0]      key_q, key_d;
    logic            down_q, down_d;
    logic            note_q, note_d;
    logic            new_note_q, new_note_d;

    logic       tick, scan_done, accept, raw_valid, raw_is_note;
    logic [3:0] raw_idx;
    logic [4:0] raw_code;

    function automatic logic [11:0] note_freq(input logic [3:0] idx);
        case (idx)
            4'd0:    note_freq = 12'd261;
            4'd1:    note_freq = 12'd277;
            4'd2:    note_freq = 12'd293;
            4'd3:    note_freq = 12'd311;
            4'd4:    note_freq = 12'd330;
            4'd5:    note_freq = 12'd349;
            4'd6:    note_freq = 12'd370;
            4'd7:    note_freq = 12'd392;
            4'd8:    note_freq = 12'd415;
            4'd9:    note_freq = 12'd440;
            4'd10:   note_freq = 12'd466;
            4'd11:   note_freq = 12'd494;
            default: note_freq = 12'd0;
        endcase
    endfunction

    // Two-flop row synchronizer; idle rows read high (pulled up).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Column divider, column stepping and scan-vector capture.
    always_comb begin
        tick   = (div_q == DivMax);
        div_d  = tick ? '0 : div_q + 1'b1;
        c_d    = tick ? c_q + 2'd1 : c_q;
        scan_d = scan_q;
        if (tick) begin
            scan_d[{c_q, 2'b00} +: 4] = ~row_sync_q;
        end
        scan_done = tick && (c_q == 2'd3);
    end

    // Lowest set scan bit wins, so simultaneous keys still yield a single code.
    always_comb begin
        raw_valid = |scan_d;
        raw_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (scan_d[i]) begin
                raw_idx = 4'(i);
            end
        end
        raw_code    = {raw_valid, raw_idx};
        raw_is_note = raw_valid && (raw_idx < 4'd12);
    end

    // Debounce on whole scans: count consecutive equal raw codes, saturating.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (scan_done) begin
            prev_d = raw_code;
            if (raw_code == prev_q) begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
        accept = scan_done && (cnt_d == CntMax);
    end

    // Output next-state: update only on acceptance; key holds across release.
    always_comb begin
        freq_d     = freq_q;
        key_d      = key_q;
        down_d     = down_q;
        note_d     = note_q;
        new_note_d = 1'b0;
        if (accept) begin
            if (raw_valid) begin
                key_d      = raw_idx;
                down_d     = 1'b1;
                note_d     = raw_is_note;
                freq_d     = raw_is_note ? note_freq(raw_idx) : 12'd0;
                new_note_d = raw_is_note && (!note_q || (key_q != raw_idx));
            end else begin
                down_d = 1'b0;
                note_d = 1'b0;
                freq_d = 12'd0;
            end
        end
    end

    // State registers; reset discards any partial scan or debounce progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            c_q        <= 2'd0;
            scan_q     <= 16'd0;
            prev_q     <= 5'd0;
            cnt_q      <= '0;
            freq_q     <= 12'd0;
            key_q      <= 4'd0;
            down_q     <= 1'b0;
            note_q     <= 1'b0;
            new_note_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            c_q        <= c_d;
            scan_q     <= scan_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            freq_q     <= freq_d;
            key_q      <= key_d;
            down_q     <= down_d;
            note_q     <= note_d;
            new_note_q <= new_note_d;
        end
    end

    assign col      = ~(4'b0001 << c_q);
    assign freq     = freq_q;
    assign key      = key_q;
    assign key_down = down_q;
    assign note_on  = note_q;
    assign new_note = new_note_q;

endmodule

// File: doc/note_keypad.md
# note_keypad

Scans a 4x4 membrane keypad and turns a held key into the 12-bit note frequency consumed by the tone generator and the 7-segment note display. It is the input end of the note path: it drives keypad columns, samples rows, debounces whole scans, and publishes one stable key code and its frequency.

## Interface

- SCAN_DIV, 50000, clock cycles each column stays driven (1 kHz column rate at 50 MHz); must be >= 4
- DEBOUNCE, 4, consecutive identical full scans required to accept a new key state; must be >= 1
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row  input  4  keypad row lines, active-low (pulled up externally)
- col  output  4  keypad column drive, active-low one-hot
- freq  output  12  accepted note frequency in Hz, 0 when no note key
- key  output  4  accepted key index (col*4 + row)
- key_down  output  1  a key is accepted as held
- note_on  output  1  accepted key is a note key (index 0..11)
- new_note  output  1  one-cycle pulse when a different note key is accepted

## Operation

- row passes through a 2-flop synchronizer before use.
- Divider counts 0..SCAN_DIV-1; tick asserts on the cycle count = SCAN_DIV-1.
- Column index c (2 bits) drives col = ~(1 << c). On tick: sample synchronized row into scan bits [c*4+3 : c*4] (bit set where row is low), then c <= c+1 (wraps 3 -> 0).
- Scan complete on the tick where c = 3. Raw code formed from the 16-bit scan vector including the bits sampled on that tick: valid = any bit set; idx = lowest set bit index (priority to lowest index, multiple keys never produce multiple codes).
- Debounce: raw code {valid, idx} compared with previous scan's raw code. Equal -> stable count increments, saturating at DEBOUNCE-1; different -> stable count = 0. Previous raw code always updated. DEBOUNCE = 1 accepts every scan.
- Acceptance when stable count reaches DEBOUNCE-1 (including the scan that reaches it, and every later equal scan):
  - valid, idx 0..11: key = idx, key_down = 1, note_on = 1, freq = table[idx]
  - valid, idx 12..15: key = idx, key_down = 1, note_on = 0, freq = 0
  - not valid: key holds last value, key_down = 0, note_on = 0, freq = 0
- Frequency table idx 0..11: 261, 277, 293, 311, 330, 349, 370, 392, 415, 440, 466, 494 (C..B).
- new_note pulses on acceptance when result is a note key and (note_on was 0 or key != idx). Re-acceptance of the same held note never pulses.

## Timing

- Reset values: col = 4'b1110, c = 0, divider 0, scan vector 0, previous raw code = not valid, stable count 0, freq = 0, key = 0, key_down = 0, note_on = 0, new_note = 0.
- Reset mid-scan or mid-debounce discards all partial state; first accepted result requires DEBOUNCE full scans after release of rst.
- Full scan period 4*SCAN_DIV cycles.
- Outputs (freq, key, key_down, note_on, new_note) register on the clock edge after the completing tick; new_note high exactly one cycle.
- Press-to-output latency: DEBOUNCE scans, plus up to one partial scan, plus 1 cycle; release-to-freq=0 same bound.
- Row changes within the 2-flop sync window before a tick are not guaranteed captured that scan.
- Between acceptances all outputs hold; new_note 0.

## Test plan

- SCAN_DIV=8, DEBOUNCE=3; after reset, no keys -> col steps 1110,1101,1011,0111 every 8 cycles; freq=0, key_down=0, new_note never asserts.
- Hold key 9 (col 2, row 1) from reset -> after 3rd full scan completes, +1 cycle: freq=440, key=9, note_on=1, new_note one-cycle pulse; stays with no further pulses while held.
- Hold key 9, then switch to key 0 -> freq=261 after 3 scans of key 0, new_note pulses once; release -> freq=0, key_down=0, key stays 0, no pulse.
- Key 5 bouncing (alternating pressed/released per scan) for 10 scans -> outputs never change; then steady 3 scans -> freq=349.
- Keys 3 and 14 held together -> key=3, freq=311; only key 14 -> key_down=1, note_on=0, freq=0, no new_note.
- Assert rst mid-debounce of key 2 -> all outputs reset immediately; held key reaccepted (freq=293) only after 3 new full scans.
